issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Issue-control stage between the instruction decoder and the execute/register-file datapath.
- Takes decoded fields (opcode, rd, rs1, rs2) under a valid/ready handshake and tracks pending register writes in a 32-bit scoreboard.
- Holds back any instruction with a RAW or WAW hazard, and presents hazard-free instructions through a one-entry registered issue slot.
- Writeback clears scoreboard bits; flush discards the issue slot.

Parameters:
- NUM_REGS, 32, number of architectural registers (scoreboard width).
- REG_W, 5, register-index width; must satisfy 2**REG_W == NUM_REGS.
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- dec_valid  input  1  decoder presents an instruction.
- dec_ready  output  1  this block accepts the instruction this cycle.
- dec_opcode  input  7  decoded opcode.
- dec_rd  input  REG_W  destination register.
- dec_rs1  input  REG_W  source register 1.
- dec_rs2  input  REG_W  source register 2.
- iss_valid  output  1  issue slot holds an instruction.
- iss_ready  input  1  execute stage consumes the issue slot this cycle.
- iss_opcode  output  7  issued opcode.
- iss_rd  output  REG_W  issued destination register.
- iss_rs1  output  REG_W  issued source register 1.
- iss_rs2  output  REG_W  issued source register 2.
- wb_valid  input  1  writeback completes this cycle.
- wb_rd  input  REG_W  register being written back.
- flush  input  1  discard the issue-slot contents.
- busy_mask  output  NUM_REGS  scoreboard; bit n=1 means a write to register n is pending.
- stall_cycles  output  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset (asynchronous, rst=1): iss_valid=0; iss_opcode, iss_rd, iss_rs1, iss_rs2 = 0; busy_mask=0; stall_cycles=0. dec_ready is combinational and evaluates to 1 after reset with no hazard. Reset mid-operation drops the slot and all pending bits.
- Operand usage is decoded from dec_opcode; only used operands participate in hazard checks.
  - 0110011: rs1, rs2, rd.
  - 0010011, 0000011, 1100111: rs1, rd.
  - 0100011, 1100011: rs1, rs2; no rd.
  - 0110111, 0010111, 1101111: rd only.
  - Any other opcode: no operands, no rd; the instruction still issues.
- Register 0 is never busy: bit 0 of busy_mask is hard 0, and rd=0 never sets a bit.
- Effective busy bit: eff_busy[n] = busy_mask[n] & ~(wb_valid & wb_rd==n). Writeback bypasses the hazard check in the same cycle.
- hazard = (use_rs1 & eff_busy[rs1]) | (use_rs2 & eff_busy[rs2]) | (use_rd & eff_busy[rd]). The rd term covers WAW.
- dec_ready = ~flush & ~hazard & (~iss_valid | iss_ready). The combinational path from dec_* to dec_ready is allowed.
- Accept (dec_valid & dec_ready):
  - Issue slot loads the fields; iss_valid=1 next cycle. Latency from accept to iss_valid is 1 cycle.
  - If use_rd and rd≠0, busy_mask[rd] is set next cycle.
- Slot consume: iss_valid & iss_ready with no accept → iss_valid=0 next cycle. Consume and accept in the same cycle → slot reloads, full throughput of 1 per cycle.
- Slot contents are stable while iss_valid & ~iss_ready.
- Writeback: wb_valid clears busy_mask[wb_rd] next cycle. wb_rd=0 has no effect. wb_valid to a non-busy register is ignored.
- Same register set and cleared in one cycle: the set wins, so the bit stays 1.
- Flush:
  - Next cycle iss_valid=0, and the slot's rd bit is cleared if the slot was valid with use_rd and rd≠0.
  - dec_ready=0 during flush, so there is no accept.
  - All other pending bits are kept; those instructions are already in execute and will write back.
  - If flush and wb target the same bit, it is cleared.
- stall_cycles increments when dec_valid & hazard & ~flush, and saturates at all-ones.

Test Plan:
- Reset then back-to-back independent ops: add x1,x2,x3 (rd=1), then add x4,x5,x6, with iss_ready=1 → both accepted on consecutive cycles; busy_mask=0x12 after 2 cycles; stall_cycles=0.
- RAW stall: issue rd=5 (0110011); next instruction rs1=5 → dec_ready=0 and stall_cycles increments per cycle; assert wb_valid, wb_rd=5 → same-cycle accept via bypass; busy_mask bit5 re-set by the new rd if the new rd=5.
- WAW and x0: issue rd=0 → busy_mask stays 0. Issue rd=7, then another rd=7 → blocked until wb_rd=7.
- Backpressure: iss_ready=0 with a valid slot → dec_ready=0 and iss_* stable for 10 cycles. Release → slot consumed and the next instruction loaded in the same cycle.
- Flush: slot holds rd=9 with bit9 set and bit3 set from an earlier op; pulse flush → iss_valid=0, busy_mask=0x008. Async rst asserted mid-stall → all outputs 0 immediately.
- Counter saturation with STALL_CNT_W=4: hold a hazard for 20 cycles → stall_cycles=15. Store opcode 0100011 with rd field=12 → no bit 12 set.

Source files
------------

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//   Issue-control stage sitting between the instruction decoder and the
//   execute/register-file datapath. Decoded instructions arrive on a
//   valid/ready handshake. A per-register scoreboard tracks pending writes.
//   Instructions with a RAW or WAW hazard are held back. Hazard-free
//   instructions are presented through a one-entry registered issue slot.
//   Writeback clears scoreboard bits, and flush discards the issue slot.
//
// Ports
//   clk, rst                       : clock (rising edge), async active-high reset
//   dec_valid/dec_ready            : decoder handshake
//   dec_opcode/rd/rs1/rs2          : decoded instruction fields
//   iss_valid/iss_ready            : issue-slot handshake to execute
//   iss_opcode/rd/rs1/rs2          : issue-slot contents
//   wb_valid, wb_rd                : writeback completion
//   flush                          : discard issue-slot contents
//   busy_mask                      : scoreboard, bit n = write to xn pending
//   stall_cycles                   : saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int REG_W       = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic [6:0]             dec_opcode,
    input  logic [REG_W-1:0]       dec_rd,
    input  logic [REG_W-1:0]       dec_rs1,
    input  logic [REG_W-1:0]       dec_rs2,
    output logic                   iss_valid,
    input  logic                   iss_ready,
    output logic [6:0]             iss_opcode,
    output logic [REG_W-1:0]       iss_rd,
    output logic [REG_W-1:0]       iss_rs1,
    output logic [REG_W-1:0]       iss_rs2,
    input  logic                   wb_valid,
    input  logic [REG_W-1:0]       wb_rd,
    input  logic                   flush,
    output logic [NUM_REGS-1:0]    busy_mask,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic                   r_iss_valid;
    logic                   r_iss_use_rd;
    logic [6:0]             r_iss_opcode;
    logic [REG_W-1:0]       r_iss_rd;
    logic [REG_W-1:0]       r_iss_rs1;
    logic [REG_W-1:0]       r_iss_rs2;
    logic [NUM_REGS-1:0]    r_busy;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic                   w_use_rs1;
    logic                   w_use_rs2;
    logic                   w_use_rd;
    logic [NUM_REGS-1:0]    w_wb_hit;
    logic [NUM_REGS-1:0]    w_eff_busy;
    logic [NUM_REGS-1:0]    w_busy_next;
    logic                   w_hazard;
    logic                   w_dec_ready;
    logic                   w_accept;

    // Operand usage decoded from the opcode; unknown opcodes use nothing.
    always_comb begin
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        case (dec_opcode)
            7'b0110011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                w_use_rd  = 1'b1;
            end
            default: ;
        endcase
    end

    // One-hot writeback decode; a same-cycle writeback hides the busy bit
    // from the hazard check so the dependent instruction issues immediately.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wb_hit
            assign w_wb_hit[gi] = wb_valid && (wb_rd == REG_W'(gi));
        end
    endgenerate

    assign w_eff_busy = r_busy & ~w_wb_hit;

    // The rd term catches WAW: a second writer must wait for the first.
    assign w_hazard = (w_use_rs1 && w_eff_busy[dec_rs1])
                    | (w_use_rs2 && w_eff_busy[dec_rs2])
                    | (w_use_rd  && w_eff_busy[dec_rd]);

    assign w_dec_ready = !flush && !w_hazard && (!r_iss_valid || iss_ready);
    assign w_accept    = dec_valid && w_dec_ready;

    // Clears are applied first so that a set in the same cycle wins.
    // Flush and accept are mutually exclusive (dec_ready is low on flush).
    always_comb begin
        w_busy_next = r_busy & ~w_wb_hit;
        if (flush && r_iss_valid && r_iss_use_rd) begin
            w_busy_next[r_iss_rd] = 1'b0;
        end
        if (w_accept && w_use_rd) begin
            w_busy_next[dec_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;  // x0 is never pending
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_valid  <= 1'b0;
            r_iss_use_rd <= 1'b0;
            r_iss_opcode <= '0;
            r_iss_rd     <= '0;
            r_iss_rs1    <= '0;
            r_iss_rs2    <= '0;
            r_busy       <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_busy <= w_busy_next;

            if (flush) begin
                r_iss_valid <= 1'b0;
            end else if (w_accept) begin
                r_iss_valid  <= 1'b1;
                r_iss_use_rd <= w_use_rd;
                r_iss_opcode <= dec_opcode;
                r_iss_rd     <= dec_rd;
                r_iss_rs1    <= dec_rs1;
                r_iss_rs2    <= dec_rs2;
            end else if (iss_ready) begin
                r_iss_valid <= 1'b0;
            end

            if (dec_valid && w_hazard && !flush && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
        end
    end

    assign dec_ready    = w_dec_ready;
    assign iss_valid    = r_iss_valid;
    assign iss_opcode   = r_iss_opcode;
    assign iss_rd       = r_iss_rd;
    assign iss_rs1      = r_iss_rs1;
    assign iss_rs2      = r_iss_rs2;
    assign busy_mask    = r_busy;
    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
//   Directed scenarios followed by randomized traffic. A reference model
//   tracks pending registers as a plain array and the issue slot as a queue
//   of expected instructions; a separate monitor pops that queue whenever
//   the DUT hands an instruction to execute.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;

    localparam int CW = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dec_valid = 1'b0;
    logic          dec_ready;
    logic [6:0]    dec_opcode = '0;
    logic [4:0]    dec_rd = '0, dec_rs1 = '0, dec_rs2 = '0;
    logic          iss_valid;
    logic          iss_ready = 1'b0;
    logic [6:0]    iss_opcode;
    logic [4:0]    iss_rd, iss_rs1, iss_rs2;
    logic          wb_valid = 1'b0;
    logic [4:0]    wb_rd = '0;
    logic          flush = 1'b0;
    logic [31:0]   busy_mask;
    logic [CW-1:0] stall_cycles;

    issue_scoreboard #(.NUM_REGS(32), .REG_W(5), .STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_opcode(iss_opcode), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_mask(busy_mask), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        bit         use_rd;
    } ins_t;

    int   total = 0;
    int   bad   = 0;
    ins_t exp_q[$];

    // Reference model state
    bit   m_pend[32];
    int   m_cnt;
    bit   m_slot_valid;
    ins_t m_slot;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void uses(input logic [6:0] op, output bit u1, output bit u2, output bit ud);
        u1 = 0; u2 = 0; ud = 0;
        if (op == 7'b0110011) begin u1 = 1; u2 = 1; ud = 1; end
        else if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) begin u1 = 1; ud = 1; end
        else if (op == 7'b0100011 || op == 7'b1100011) begin u1 = 1; u2 = 1; end
        else if (op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111) ud = 1;
    endfunction

    function automatic logic [31:0] pend_word();
        logic [31:0] w = '0;
        for (int n = 0; n < 32; n++) w[n] = m_pend[n];
        return w;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 32; n++) m_pend[n] = 0;
        m_cnt = 0;
        m_slot_valid = 0;
        exp_q.delete();
    endtask

    // Evaluated mid-cycle with this cycle's inputs applied: check the DUT
    // against the model, then advance the model to the next cycle.
    task automatic model_cycle();
        bit u1, u2, ud, haz, rdy, acc;
        bit eff[32];
        ins_t ni;
        uses(dec_opcode, u1, u2, ud);
        for (int n = 0; n < 32; n++) eff[n] = m_pend[n] && !(wb_valid && wb_rd == 5'(n));
        haz = (u1 && eff[dec_rs1]) || (u2 && eff[dec_rs2]) || (ud && eff[dec_rd]);
        rdy = !flush && !haz && (!m_slot_valid || iss_ready);
        chk("dec_ready", 32'(dec_ready), 32'(rdy));
        chk("iss_valid", 32'(iss_valid), 32'(m_slot_valid));
        chk("busy_mask", busy_mask, pend_word());
        chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        if (m_slot_valid)
            chk("iss_hold", 32'({iss_opcode, iss_rd, iss_rs1, iss_rs2}),
                32'({m_slot.op, m_slot.rd, m_slot.rs1, m_slot.rs2}));
        acc = dec_valid && rdy;
        if (wb_valid && wb_rd != 0) m_pend[wb_rd] = 0;
        if (flush && m_slot_valid && m_slot.use_rd && m_slot.rd != 0) m_pend[m_slot.rd] = 0;
        if (acc && ud && dec_rd != 0) m_pend[dec_rd] = 1;
        if (dec_valid && haz && !flush && m_cnt < (1 << CW) - 1) m_cnt++;
        if (flush) begin
            if (m_slot_valid && exp_q.size() != 0) void'(exp_q.pop_back());
            m_slot_valid = 0;
        end else if (acc) begin
            ni.op = dec_opcode; ni.rd = dec_rd; ni.rs1 = dec_rs1; ni.rs2 = dec_rs2; ni.use_rd = ud;
            exp_q.push_back(ni);
            m_slot = ni;
            m_slot_valid = 1;
        end else if (iss_ready) begin
            m_slot_valid = 0;
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input bit ir,
                        input bit wv, input logic [4:0] wr, input bit fl);
        dec_valid = v; dec_opcode = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
        iss_ready = ir; wb_valid = wv; wb_rd = wr; flush = fl;
        #2;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit wv, input logic [4:0] wr);
        step(0, 7'd0, 5'd0, 5'd0, 5'd0, 1, wv, wr, 0);
    endtask

    // Monitor: compare every instruction the DUT hands to execute.
    always @(negedge clk) begin
        if (!rst && iss_valid && iss_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL issue_unexpected actual=%0h required=none", {iss_opcode, iss_rd, iss_rs1, iss_rs2});
            end else begin
                ins_t e;
                e = exp_q.pop_front();
                chk("issue", 32'({iss_opcode, iss_rd, iss_rs1, iss_rs2}), 32'({e.op, e.rd, e.rs1, e.rs2}));
            end
        end
    end

    initial begin
        int issued;
        model_reset();
        @(posedge clk); #1;
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back independent ops
        step(1, OP_R, 5'd1, 5'd2, 5'd3, 1, 0, 5'd0, 0);
        step(1, OP_R, 5'd4, 5'd5, 5'd6, 1, 0, 5'd0, 0);
        chk("b2b_busy", busy_mask, 32'h12);
        chk("b2b_stall", 32'(stall_cycles), 32'd0);
        idle(1, 5'd1); idle(1, 5'd4);

        // RAW stall, released by same-cycle writeback bypass; new rd=5
        step(1, OP_R, 5'd5, 5'd0, 5'd0, 1, 0, 5'd0, 0);
        repeat (3) step(1, OP_I, 5'd5, 5'd5, 5'd0, 1, 0, 5'd0, 0);
        step(1, OP_I, 5'd5, 5'd5, 5'd0, 1, 1, 5'd5, 0);
        chk("raw_busy", busy_mask, 32'h20);
        idle(1, 5'd5);

        // x0 never busy; WAW on x7
        step(1, OP_R, 5'd0, 5'd1, 5'd2, 1, 0, 5'd0, 0);
        chk("x0_busy", busy_mask, 32'd0);
        step(1, OP_LUI, 5'd7, 5'd0, 5'd0, 1, 0, 5'd0, 0);
        repeat (2) step(1, OP_LUI, 5'd7, 5'd0, 5'd0, 1, 0, 5'd0, 0);
        step(1, OP_LUI, 5'd7, 5'd0, 5'd0, 1, 1, 5'd7, 0);
        idle(1, 5'd7);

        // Backpressure: slot held for 10 cycles, then consume + reload
        step(1, OP_R, 5'd10, 5'd1, 5'd1, 0, 0, 5'd0, 0);
        repeat (10) step(1, OP_I, 5'd11, 5'd2, 5'd0, 0, 0, 5'd0, 0);
        step(1, OP_I, 5'd11, 5'd2, 5'd0, 1, 0, 5'd0, 0);
        chk("bp_reload", 32'({iss_valid, iss_rd}), 32'({1'b1, 5'd11}));
        idle(1, 5'd10); idle(1, 5'd11);

        // Flush drops the slot's rd bit but keeps x3 pending
        step(1, OP_R, 5'd3, 5'd1, 5'd2, 1, 0, 5'd0, 0);
        idle(0, 5'd0);
        step(1, OP_R, 5'd9, 5'd1, 5'd2, 0, 0, 5'd0, 0);
        step(0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1);
        chk("flush_busy", busy_mask, 32'h008);
        chk("flush_valid", 32'(iss_valid), 32'd0);
        idle(1, 5'd3);

        // Counter saturation
        step(1, OP_R, 5'd13, 5'd0, 5'd0, 1, 0, 5'd0, 0);
        repeat (20) step(1, OP_I, 5'd14, 5'd13, 5'd0, 1, 0, 5'd0, 0);
        chk("stall_sat", 32'(stall_cycles), 32'd15);
        idle(1, 5'd13);

        // Store with rd field 12 sets nothing
        step(1, OP_S, 5'd12, 5'd1, 5'd2, 1, 0, 5'd0, 0);
        idle(0, 5'd0);
        chk("store_busy", busy_mask, 32'd0);

        // Async reset mid-stall
        step(1, OP_R, 5'd14, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        dec_valid = 1; dec_opcode = OP_I; dec_rd = 5'd15; dec_rs1 = 5'd14; iss_ready = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_outputs", 32'({iss_valid, iss_opcode, iss_rd, iss_rs1, iss_rs2, stall_cycles}), 32'd0);
        chk("arst_busy", busy_mask, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(0, 5'd0);

        // Randomized traffic; small register range keeps hazards frequent
        issued = 0;
        for (int c = 0; c < 600; c++) begin
            logic [6:0] ops[10];
            bit fl;
            ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                    7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};
            fl = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 3) != 0, ops[$urandom_range(0, 9)],
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 fl ? 1'b0 : ($urandom_range(0, 9) < 7), $urandom_range(0, 2) != 0,
                 5'($urandom_range(0, 7)), fl);
            issued++;
        end

        // Drain and confirm nothing expected was lost
        for (int n = 1; n < 32; n++) if (m_pend[n]) idle(1, 5'(n));
        idle(0, 5'd0);
        idle(0, 5'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", busy_mask, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
